// File: rtl/lu_serial_sequencer.sv
// Bit-serial initiator for a 1-bit logic unit slice.
// Streams two operands LSB first and assembles the result word.
module lu_serial_sequencer #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             lu_a,
    output logic             lu_b,
    output logic [2:0]       lu_sel,
    input  logic             lu_s
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nx;
    logic [2:0]       op_q;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last;

    assign accept = start && (state != RUN);
    assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));
    assign acc_nx = {lu_s, acc[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // LU drive comes only from registers, so it is stable all cycle
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        lu_a   = 1'b0;
        lu_b   = 1'b0;
        lu_sel = 3'b000;
        unique case (state)
            RUN: begin
                busy   = 1'b1;
                lu_a   = a_sh[0];
                lu_b   = b_sh[0];
                lu_sel = op_q;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            op_q   <= 3'b000;
            cnt    <= '0;
            result <= '0;
            zero   <= 1'b1;
        end else if (accept) begin
            a_sh <= a_in;
            b_sh <= b_in;
            op_q <= op;
            acc  <= '0;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            acc  <= acc_nx;
            cnt  <= cnt + 1'b1;
            // final bit goes straight into result with the last sample
            if (last) begin
                result <= acc_nx;
                zero   <= (acc_nx == '0);
            end
        end
    end

endmodule

// File: tb/tb_lu_serial_sequencer.sv
// Randomized and directed bench for lu_serial_sequencer.
// Word-level reference model; a bit-level LU slice drives lu_s.
module tb_lu_serial_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] op_i;
    logic [7:0] a_i;
    logic [7:0] b_i;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       zero;
    logic       lu_a;
    logic       lu_b;
    logic [2:0] lu_sel;
    logic       lu_s;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] prev_res;

    always #5 clk = ~clk;

    lu_serial_sequencer #(.WIDTH(8), .CW(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op_i),
        .a_in   (a_i),
        .b_in   (b_i),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zero   (zero),
        .lu_a   (lu_a),
        .lu_b   (lu_b),
        .lu_sel (lu_sel),
        .lu_s   (lu_s)
    );

    // 1-bit logic unit slice
    always_comb begin
        lu_s = 1'b0;
        case (lu_sel)
            3'd0: lu_s = ~lu_a;
            3'd1: lu_s = lu_a & lu_b;
            3'd2: lu_s = ~(lu_a & lu_b);
            3'd3: lu_s = lu_a | lu_b;
            3'd4: lu_s = ~(lu_a | lu_b);
            3'd5: lu_s = lu_a ^ lu_b;
            3'd6: lu_s = ~(lu_a ^ lu_b);
            default: lu_s = lu_a & ~lu_b;
        endcase
    end

    function automatic logic [7:0] ref_fn(input logic [2:0] o,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
        case (o)
            3'd0: return ~a;
            3'd1: return a & b;
            3'd2: return ~(a & b);
            3'd3: return a | b;
            3'd4: return ~(a | b);
            3'd5: return a ^ b;
            3'd6: return ~(a ^ b);
            default: return a & ~b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge of the DONE cycle.
    task automatic issue(input logic [2:0] o, input logic [7:0] a,
                         input logic [7:0] b, input bit noise);
        logic [7:0] exp;
        exp   = ref_fn(o, a, b);
        start = 1'b1;
        op_i  = o;
        a_i   = a;
        b_i   = b;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            check("run_busy", busy, 1);
            check("run_done", done, 0);
            check("lu_a", lu_a, a[i]);
            check("lu_b", lu_b, b[i]);
            check("lu_sel", lu_sel, o);
            check("run_result_hold", result, prev_res);
            check("run_zero_hold", zero, prev_res == 0);
            if (noise && i < 7) begin
                start = 1'b1;
                op_i  = 3'($urandom);
                a_i   = 8'($urandom);
                b_i   = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("result", result, exp);
        check("zero", zero, exp == 0);
        check("done_lu_a", lu_a, 0);
        check("done_lu_b", lu_b, 0);
        check("done_lu_sel", lu_sel, 0);
        prev_res = exp;
    endtask

    task automatic idle_cycle();
        start = 1'b0;
        @(negedge clk);
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        check("idle_result", result, prev_res);
        check("idle_zero", zero, prev_res == 0);
        check("idle_lu_sel", lu_sel, 0);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        op_i     = 3'd0;
        a_i      = 8'h00;
        b_i      = 8'h00;
        prev_res = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 1);
        check("rst_lu_a", lu_a, 0);
        check("rst_lu_b", lu_b, 0);
        check("rst_lu_sel", lu_sel, 0);
        reset = 1'b0;
        idle_cycle();

        issue(3'b001, 8'hF0, 8'h3C, 0);
        idle_cycle();
        issue(3'b000, 8'hA5, 8'h00, 0);
        idle_cycle();
        issue(3'b101, 8'h5A, 8'h5A, 0);
        idle_cycle();
        issue(3'b110, 8'h5A, 8'h5A, 0);
        idle_cycle();
        issue(3'b010, 8'h5A, 8'h5A, 0);
        idle_cycle();
        issue(3'b100, 8'h5A, 8'h5A, 0);
        idle_cycle();
        issue(3'b111, 8'hFF, 8'h0F, 0);
        idle_cycle();
        issue(3'b011, 8'h00, 8'h81, 0);
        idle_cycle();

        // start held during RUN is ignored, then back-to-back from DONE
        issue(3'b001, 8'hC3, 8'h5F, 1);
        issue(3'b101, 8'h0F, 8'hFF, 0);
        idle_cycle();
        idle_cycle();

        // reset in the 4th RUN cycle aborts the operation
        start = 1'b1;
        op_i  = 3'b011;
        a_i   = 8'h12;
        b_i   = 8'h34;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_pre", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        prev_res = 8'h00;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_zero", zero, 1);
        idle_cycle();
        idle_cycle();
        issue(3'b011, 8'h12, 8'h34, 0);
        idle_cycle();

        for (int n = 0; n < 40; n++) begin
            issue(3'($urandom), 8'($urandom), 8'($urandom),
                  bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) != 0) idle_cycle();
        end
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
